sound_event_queue: RTL and testbench

Upstream feeder for the piezo sound engine. It collects one-cycle sound-event strobes from the game controller (select, cancel, move, capture, illegal, promotion, game over) and queues them in a small FIFO. It replays them one at a time as a `sound_code` plus a single-cycle `play_sound` pulse, never issuing a new code while the engine's `start` (busy) flag is high. This ensures back-to-back game events are heard in order instead of overwriting each other.

---
 rtl/sound_event_queue.sv | 91 +++++++++
 tb/tb_sound_event_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/sound_event_queue.sv
// sound_event_queue: queues game sound events and replays them one at a time to the piezo engine.
// Optional feature: define SOUND_QUEUE_PREEMPT_EN so that a game-over (code 7) request flushes the queue and preempts playback.
module sound_event_queue #(
  parameter int DEPTH        = 4,
  parameter int GAP_CYCLES   = 1000000,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [6:0]               evt_req,
  input  logic                     start,
  output logic [2:0]               sound_code,
  output logic                     play_sound,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     drop
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, GAP} state_t;
  state_t st, ns;
  logic [2:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [23:0] cnt, cnt_n;
  logic [2:0] code;
  logic multi, push, pop, full, accept, issue, flush, pend, drop_n;
  // Highest set strobe wins; any extra strobes in the same cycle are lost.
  always_comb begin
    code = 3'd0;
    for (int i = 0; i < 7; i++) if (evt_req[i]) code = 3'(i + 1);
  end
  assign multi = (evt_req & (evt_req - 7'd1)) != 7'd0;
  assign push  = |evt_req;
  assign full  = q_count == (AW+1)'(DEPTH);
`ifdef SOUND_QUEUE_PREEMPT_EN
  assign flush = evt_req[6];
`else
  assign flush = 1'b0;
`endif
  assign pop    = st == IDLE && q_count != '0 && !pend;
  assign accept = push && !flush && (!full || pop);
  assign drop_n = multi || (push && !flush && full && !pop) ||
                  (flush && (q_count - (AW+1)'(pop)) != '0);
  // Next state and counter; a pending preempt overrides the normal flow.
  always_comb begin
    ns    = st;
    cnt_n = cnt;
    issue = 1'b0;
    case (st)
      IDLE:      if (q_count != '0) begin issue = 1'b1; ns = WAIT_BUSY; end
      WAIT_BUSY: if (start) ns = WAIT_DONE;
                 else if (cnt >= 24'(BUSY_TIMEOUT - 1)) ns = GAP;
                 else cnt_n = cnt + 24'd1;
      WAIT_DONE: if (!start) ns = GAP;
      GAP:       if (cnt >= 24'(GAP_CYCLES - 1)) ns = IDLE;
                 else cnt_n = cnt + 24'd1;
      default:   ns = IDLE;
    endcase
    if (pend) begin
      issue = 1'b1;
      ns    = WAIT_BUSY;
    end
    if (ns != st || pend) cnt_n = 24'd0;
  end
  // FIFO storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (accept) mem[wr] <= code;
  end
  // State, pointers, occupancy and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= IDLE;
      cnt        <= 24'd0;
      rd         <= '0;
      wr         <= '0;
      q_count    <= '0;
      pend       <= 1'b0;
      play_sound <= 1'b0;
      sound_code <= 3'd0;
      drop       <= 1'b0;
    end else begin
      st         <= ns;
      cnt        <= cnt_n;
      pend       <= flush;
      play_sound <= issue;
      drop       <= drop_n;
      if (issue) sound_code <= pend ? 3'd7 : mem[rd];
      rd         <= flush ? wr : rd + AW'(pop);
      wr         <= wr + AW'(accept);
      q_count    <= flush ? '0 : q_count + (AW+1)'(accept) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_sound_event_queue.sv
// tb_sound_event_queue: directed self-checking bench for sound_event_queue (DEPTH=4, GAP_CYCLES=8, BUSY_TIMEOUT=16).
module tb_sound_event_queue;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [6:0] evt_req = 7'd0;
  logic [2:0] sound_code;
  logic play_sound;
  logic [2:0] q_count;
  logic drop;
  int checks = 0;
  int errors = 0;
  int drops = 0;

  sound_event_queue #(.DEPTH(4), .GAP_CYCLES(8), .BUSY_TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn), .evt_req(evt_req), .start(start),
    .sound_code(sound_code), .play_sound(play_sound), .q_count(q_count), .drop(drop)
  );

  always #5 clk = ~clk;

  // Count drop pulses between edges.
  always @(negedge clk) if (drop) drops++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] v);
    evt_req = v;
    tick();
    evt_req = 7'd0;
  endtask

  task automatic wait_play(input int bound, output int k);
    k = 0;
    do begin
      tick();
      k++;
    end while (!play_sound && k < bound);
  endtask

  initial begin
    int k;
    int d0;
    logic [2:0] exp_codes [4];
    exp_codes = '{3'd2, 3'd3, 3'd4, 3'd6};
    repeat (2) tick();
    check("rst_code", sound_code, 0);
    check("rst_play", play_sound, 0);
    check("rst_q", q_count, 0);
    check("rst_drop", drop, 0);
    rstn = 1'b1;
    tick();
    // single event, then engine busy for 50 clocks
    push(7'b0000100);
    check("single_q", q_count, 1);
    check("single_noplay", play_sound, 0);
    tick();
    check("single_play", play_sound, 1);
    check("single_code", sound_code, 3);
    check("single_pop", q_count, 0);
    tick();
    check("single_pulse_len", play_sound, 0);
    check("single_code_hold", sound_code, 3);
    start = 1'b1;
    repeat (10) tick();
    push(7'b0000010);
    check("busy_q", q_count, 1);
    repeat (39) tick();
    check("busy_noplay", play_sound, 0);
    start = 1'b0;
    wait_play(100, k);
    check("spacing_play", play_sound, 1);
    check("spacing_cycles", k, 10);
    check("spacing_code", sound_code, 2);
    // busy never rises: 16-clock timeout then 8-clock gap
    push(7'b0100000);
    check("timeout_q", q_count, 1);
    wait_play(100, k);
    check("timeout_play", play_sound, 1);
    check("timeout_cycles", k, 24);
    check("timeout_code", sound_code, 6);
    repeat (26) tick();
    check("idle_empty", q_count, 0);
    // three consecutive events keep their order
    d0 = drops;
    push(7'b0000001);
    check("seq_q1", q_count, 1);
    push(7'b0001000);
    check("seq_play1", play_sound, 1);
    check("seq_code1", sound_code, 1);
    check("seq_q2", q_count, 1);
    push(7'b0000100);
    check("seq_peak", q_count, 2);
    wait_play(40, k);
    check("seq_play2", play_sound, 1);
    check("seq_code2", sound_code, 4);
    wait_play(40, k);
    check("seq_play3", play_sound, 1);
    check("seq_code3", sound_code, 3);
    check("seq_nodrop", drops, d0);
    repeat (26) tick();
    // two strobes in one cycle: only the higher is kept
    push(7'b0010010);
    check("multi_drop", drop, 1);
    check("multi_q", q_count, 1);
    tick();
    check("multi_play", play_sound, 1);
    check("multi_code", sound_code, 5);
    check("multi_drop_once", drop, 0);
    // fill while busy, overflow, then push coinciding with pop
    start = 1'b1;
    push(7'b0000001);
    push(7'b0000010);
    push(7'b0000100);
    push(7'b0001000);
    check("full_q", q_count, 4);
    check("full_nodrop", drop, 0);
    push(7'b0010000);
    check("overflow_drop", drop, 1);
    check("overflow_q", q_count, 4);
    start = 1'b0;
    tick();
    check("overflow_drop_once", drop, 0);
    repeat (8) tick();
    check("gap_noplay", play_sound, 0);
    check("gap_q", q_count, 4);
    push(7'b0100000);
    check("pushpop_play", play_sound, 1);
    check("pushpop_code", sound_code, 1);
    check("pushpop_q", q_count, 4);
    check("pushpop_nodrop", drop, 0);
    for (int i = 0; i < 4; i++) begin
      wait_play(40, k);
      check("drain_play", play_sound, 1);
      check("drain_code", sound_code, exp_codes[i]);
    end
    // reset asserted in the middle of a gap
    push(7'b0000010);
    repeat (18) tick();
    check("pre_rst_q", q_count, 1);
    check("pre_rst_code", sound_code, 6);
    #2;
    rstn = 1'b0;
    #1;
    check("async_code", sound_code, 0);
    check("async_play", play_sound, 0);
    check("async_q", q_count, 0);
    check("async_drop", drop, 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_play", play_sound, 0);
      check("post_rst_q", q_count, 0);
    end
`ifdef SOUND_QUEUE_PREEMPT_EN
    // game over flushes the queue and preempts playback
    push(7'b0000001);
    tick();
    check("pre_play", play_sound, 1);
    start = 1'b1;
    push(7'b0000010);
    push(7'b0000100);
    push(7'b0001000);
    check("pre_q3", q_count, 3);
    push(7'b1000000);
    check("pre_flush_q", q_count, 0);
    check("pre_flush_drop", drop, 1);
    check("pre_flush_noplay", play_sound, 0);
    tick();
    check("pre_issue_play", play_sound, 1);
    check("pre_issue_code", sound_code, 7);
    check("pre_issue_drop", drop, 0);
    start = 1'b0;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
